mem_responder: RTL

- Simulation/formal-friendly memory responder: the target side of the core's native memory bus (mem_valid/mem_instr/mem_addr/mem_wdata/mem_wstrb -> mem_ready/mem_rdata).
- Backs a word-addressed RAM window with a programmable number of wait states.
- Checks initiator protocol rules and flags violations.
- Sits between the core and testbench, replacing the tied-high mem_ready stub so stall paths get exercised.

---
 rtl/mem_responder_if.sv | 27 ++
 rtl/mem_responder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// Native memory bus between an initiator (core or bench) and a target.
//   mem_valid  initiator -> target  request valid
//   mem_instr  initiator -> target  instruction-fetch qualifier
//   mem_addr   initiator -> target  byte address
//   mem_wdata  initiator -> target  write data
//   mem_wstrb  initiator -> target  byte write enables, 0 = read
//   mem_ready  target -> initiator  one-cycle response strobe
//   mem_rdata  target -> initiator  read data, qualified by mem_ready
interface mem_responder_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_responder.sv
// Memory responder: target side of the native memory bus backed by a
// word-addressed RAM window, with programmable wait states and initiator
// protocol checking.
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   bus           slave side of the memory bus
//   wait_cfg      wait states applied to the next captured request
//   bus_err       pulses with mem_ready for out-of-window/misaligned accesses
//   protocol_err  sticky initiator-violation flag, cleared only by reset
module mem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_responder_if.slave       bus,
    input  logic [3:0]           wait_cfg,
    output logic                 bus_err,
    output logic                 protocol_err
);
    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [32:0] WIN_BYTES = 33'(4) << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state, next_state;
    logic [3:0]              cnt, next_cnt;
    logic [31:0]             cap_addr, cap_wdata;
    logic [3:0]              cap_wstrb;
    logic                    cap_instr;
    logic                    capture, do_write, proto_set, enter_resp;
    logic [31:0]             req_addr, req_off;
    logic [3:0]              req_wstrb;
    logic                    req_hit;
    logic [ADDR_WIDTH-1:0]   req_idx;
    logic [31:0]             ram [DEPTH];

    // Request under decode: live bus in IDLE (capture edge), captured copy otherwise
    assign req_off = req_addr - BASE_ADDR;
    assign req_hit = (req_off[1:0] == 2'b00) && (req_addr >= BASE_ADDR) &&
                     ({1'b0, req_off} < WIN_BYTES);
    assign req_idx = req_off[ADDR_WIDTH+1:2];
    assign enter_resp = (next_state == RESP);

    // Next-state, counter and protocol checking
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        capture    = 1'b0;
        do_write   = 1'b0;
        proto_set  = 1'b0;
        req_addr   = cap_addr;
        req_wstrb  = cap_wstrb;
        case (state)
            IDLE: begin
                req_addr  = bus.mem_addr;
                req_wstrb = bus.mem_wstrb;
                if (bus.mem_valid) begin
                    capture    = 1'b1;
                    next_cnt   = wait_cfg;
                    next_state = (wait_cfg == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!bus.mem_valid) begin
                    next_state = IDLE;
                    next_cnt   = 4'd0;
                    proto_set  = 1'b1;
                end else if (cnt == 4'd1) begin
                    next_state = RESP;
                    next_cnt   = 4'd0;
                end else begin
                    next_cnt = cnt - 4'd1;
                end
            end
            RESP: begin
                next_state = IDLE;
                next_cnt   = 4'd0;
                // Withdrawn request in the response cycle suppresses the write
                if (!bus.mem_valid) begin
                    proto_set = 1'b1;
                end else begin
                    do_write = (cap_wstrb != 4'd0) && req_hit;
                end
            end
            default: next_state = IDLE;
        endcase
        // Initiator must hold the request stable until it completes
        if ((state != IDLE) && bus.mem_valid &&
            ((bus.mem_addr != cap_addr) || (bus.mem_wdata != cap_wdata) ||
             (bus.mem_wstrb != cap_wstrb))) begin
            proto_set = 1'b1;
        end
    end

    // State, counter and request capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            cap_wstrb <= 4'd0;
            cap_instr <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (capture) begin
                cap_addr  <= bus.mem_addr;
                cap_wdata <= bus.mem_wdata;
                cap_wstrb <= bus.mem_wstrb;
                cap_instr <= bus.mem_instr;
            end
        end
    end

    // Registered response outputs; read data sampled on the edge entering RESP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= 32'd0;
            bus_err       <= 1'b0;
            protocol_err  <= 1'b0;
        end else begin
            bus.mem_ready <= enter_resp;
            bus_err       <= enter_resp && !req_hit;
            protocol_err  <= protocol_err | proto_set;
            if (enter_resp && (req_wstrb == 4'd0)) begin
                bus.mem_rdata <= req_hit ? ram[req_idx] : ERR_RDATA;
            end else begin
                bus.mem_rdata <= 32'd0;
            end
        end
    end

    // RAM storage is not reset; byte-lane write on the edge leaving RESP
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (cap_wstrb[i]) begin
                    ram[req_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
                end
            end
        end
    end
endmodule
